// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared encodings for the EX/MEM pipeline register.
//   - ex_result_sel encodings that choose the value written back from EX.
//   - State encoding of the two-entry skid buffer.
package ex_mem_pkg;

  localparam logic [1:0] RES_ALU   = 2'd0;  // ALU output
  localparam logic [1:0] RES_IMM   = 2'd1;  // immediate (LUI)
  localparam logic [1:0] RES_PC4   = 2'd2;  // return address (JAL/JALR)
  localparam logic [1:0] RES_PCIMM = 2'd3;  // pc-relative (AUIPC)

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: valid/ready pipeline buffer for an opaque payload.
//   SKID_EN=1: two-entry skid buffer, in_ready comes straight from a flop.
//   SKID_EN=0: one register, in_ready = !out_valid || out_ready.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           drop every stored entry at the next edge, refuse input
//   in_valid/in_ready, in_data     upstream handshake and payload
//   out_valid/out_ready, out_data  downstream handshake and payload
// Stored payload is cleared whenever a slot empties, so out_data is all
// zeros while out_valid is low.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int W       = 8,
  parameter int SKID_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  generate
    if (SKID_EN != 0) begin : g_skid
      skid_state_t  state;
      logic         rdy_q;
      logic [W-1:0] head_p1;
      logic [W-1:0] skid_p1;
      logic         accept;
      logic         release_ok;

      // Flush blocks acceptance so an offer made in the flush cycle is lost.
      assign accept     = in_valid && rdy_q && !flush;
      assign release_ok = (state != ST_EMPTY) && out_ready;

      // Stage p1: head holds the oldest entry, skid catches one more while
      // downstream stalls. in_ready is registered from the next state.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          state   <= ST_EMPTY;
          rdy_q   <= 1'b1;
          head_p1 <= '0;
          skid_p1 <= '0;
        end else begin
          case (state)
            ST_EMPTY: begin
              if (accept) begin
                head_p1 <= in_data;
                state   <= ST_ONE;
              end
            end
            ST_ONE: begin
              if (accept && release_ok) begin
                head_p1 <= in_data;
              end else if (accept) begin
                skid_p1 <= in_data;
                state   <= ST_TWO;
                rdy_q   <= 1'b0;
              end else if (release_ok) begin
                head_p1 <= '0;
                state   <= ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (release_ok) begin
                head_p1 <= skid_p1;
                skid_p1 <= '0;
                state   <= ST_ONE;
                rdy_q   <= 1'b1;
              end
            end
            default: begin
              state   <= ST_EMPTY;
              rdy_q   <= 1'b1;
              head_p1 <= '0;
              skid_p1 <= '0;
            end
          endcase
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state != ST_EMPTY);
      assign out_data  = head_p1;
    end else begin : g_reg
      logic         vld_p1;
      logic [W-1:0] head_p1;
      logic         accept;
      logic         release_ok;

      assign in_ready   = !vld_p1 || out_ready;
      assign accept     = in_valid && in_ready && !flush;
      assign release_ok = vld_p1 && out_ready;

      // Stage p1: single register, refilled in the same cycle it drains.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          vld_p1  <= 1'b0;
          head_p1 <= '0;
        end else if (accept) begin
          vld_p1  <= 1'b1;
          head_p1 <= in_data;
        end else if (release_ok) begin
          vld_p1  <= 1'b0;
          head_p1 <= '0;
        end
      end

      assign out_valid = vld_p1;
      assign out_data  = head_p1;
    end
  endgenerate

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with result select.
//   Computes the EX result (ALU, imm, pc+4, pc+imm) in the accept cycle and
//   stores it together with the rest of the MEM payload in pipe_skid_buf.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready               EX handshake
//   in_regWAddr, in_regRData2, in_imm, alu_result, in_pc   EX payload
//   ex_result_sel, in_mem_rd, in_mem_wr                    select, mem ctrl
//   flush                           discard all stored entries
//   out_valid/out_ready             MEM handshake
//   data_regWAddr, data_regRData2, data_result, data_pc,
//   data_mem_rd, data_mem_wr        MEM payload (zero while out_valid=0)
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_regWAddr,
  input  logic [XLEN-1:0]   in_regRData2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [1:0]        ex_result_sel,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] data_regWAddr,
  output logic [XLEN-1:0]   data_regRData2,
  output logic [XLEN-1:0]   data_result,
  output logic [XLEN-1:0]   data_pc,
  output logic              data_mem_rd,
  output logic              data_mem_wr
);

  localparam int PAY_W = REG_AW + 3 * XLEN + 2;

  // Sums wrap modulo 2^XLEN; the carry is intentionally dropped.
  function automatic logic [XLEN-1:0] calc_result(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] pc
  );
    logic [XLEN-1:0] r;
    case (sel)
      RES_ALU:   r = alu;
      RES_IMM:   r = imm;
      RES_PC4:   r = pc + XLEN'(4);
      RES_PCIMM: r = pc + imm;
      default:   r = alu;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0]  result_p0;
  logic [PAY_W-1:0] pay_p0;
  logic [PAY_W-1:0] pay_p1;

  // Stage p0: result mux and payload packing, combinational in accept cycle.
  assign result_p0 = calc_result(ex_result_sel, alu_result, in_imm, in_pc);
  assign pay_p0    = {in_regWAddr, in_regRData2, result_p0, in_pc,
                      in_mem_rd, in_mem_wr};

  pipe_skid_buf #(
    .W       (PAY_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_p0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_p1)
  );

  // Stage p1: unpack the stored payload toward MEM.
  assign {data_regWAddr, data_regRData2, data_result, data_pc,
          data_mem_rd, data_mem_wr} = pay_p1;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe (SKID_EN=1). A scoreboard queue holds
// the expected payload of every accepted entry; each release pops and
// compares. Directed sequences cover result select, skid fill, flush and
// reset, followed by a short randomised phase.
module tb_ex_mem_pipe;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int PAY_W  = REG_AW + 3 * XLEN + 2;

  typedef logic [PAY_W-1:0] pay_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_regWAddr;
  logic [XLEN-1:0]   in_regRData2;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   in_pc;
  logic [1:0]        ex_result_sel;
  logic              in_mem_rd;
  logic              in_mem_wr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] data_regWAddr;
  logic [XLEN-1:0]   data_regRData2;
  logic [XLEN-1:0]   data_result;
  logic [XLEN-1:0]   data_pc;
  logic              data_mem_rd;
  logic              data_mem_wr;

  ex_mem_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .SKID_EN(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_regWAddr    (in_regWAddr),
    .in_regRData2   (in_regRData2),
    .in_imm         (in_imm),
    .alu_result     (alu_result),
    .in_pc          (in_pc),
    .ex_result_sel  (ex_result_sel),
    .in_mem_rd      (in_mem_rd),
    .in_mem_wr      (in_mem_wr),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_regWAddr  (data_regWAddr),
    .data_regRData2 (data_regRData2),
    .data_result    (data_result),
    .data_pc        (data_pc),
    .data_mem_rd    (data_mem_rd),
    .data_mem_wr    (data_mem_wr)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_rel    = 0;
  bit   mon_en   = 1'b0;
  bit   stall_prev = 1'b0;
  pay_t prev_pay;
  pay_t exp_q[$];
  pay_t out_pay;

  assign out_pay = {data_regWAddr, data_regRData2, data_result, data_pc,
                    data_mem_rd, data_mem_wr};

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [XLEN-1:0] model_result(
    input logic [1:0] sel, input logic [XLEN-1:0] pc, imm, alu);
    case (sel)
      2'd0:    return alu;
      2'd1:    return imm;
      2'd2:    return pc + 32'd4;
      default: return pc + imm;
    endcase
  endfunction

  function automatic pay_t exp_pay(
    input logic [REG_AW-1:0] wa, input logic [XLEN-1:0] rd2, imm, alu, pc,
    input logic [1:0] sel, input logic mr, mw);
    return {wa, rd2, model_result(sel, pc, imm, alu), pc, mr, mw};
  endfunction

  task automatic offer(input logic [REG_AW-1:0] wa, input logic [XLEN-1:0] rd2,
                       imm, alu, pc, input logic [1:0] sel, input logic mr, mw);
    in_valid      = 1'b1;
    in_regWAddr   = wa;
    in_regRData2  = rd2;
    in_imm        = imm;
    alu_result    = alu;
    in_pc         = pc;
    ex_result_sel = sel;
    in_mem_rd     = mr;
    in_mem_wr     = mw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle before the next active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("release_expected", 128'(exp_q.size() != 0), 128'd1);
        else check("release_payload", 128'(out_pay), 128'(exp_q.pop_front()));
        n_rel++;
      end
      if (!out_valid)
        check("bubble_zero", 128'({data_regWAddr, data_mem_rd, data_mem_wr}), 128'd0);
      if (stall_prev) check("stall_stable", 128'(out_pay), 128'(prev_pay));
      stall_prev = out_valid && !out_ready && !reset && !flush;
      prev_pay   = out_pay;
      if (reset || flush) exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back(exp_pay(in_regWAddr, in_regRData2, in_imm, alu_result,
                                in_pc, ex_result_sel, in_mem_rd, in_mem_wr));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    step(); step();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_payload", 128'(out_pay), 128'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // AUIPC: pc + imm
    out_ready = 1'b1;
    offer(5'd3, 32'h11, 32'h0002_0000, 32'hDEAD, 32'h1000, 2'd3, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check("auipc_valid", 128'(out_valid), 128'd1);
    check("auipc_result", 128'(data_result), 128'h0002_1000);
    check("auipc_pc", 128'(data_pc), 128'h1000);
    step();
    check("auipc_drained", 128'(out_valid), 128'd0);

    // JAL wrap-around, then LUI back-to-back
    offer(5'd4, 32'h22, 32'h0, 32'h5, 32'hFFFF_FFFC, 2'd2, 1'b0, 1'b0);
    step();
    check("pc4_wrap", 128'(data_result), 128'h0);
    offer(5'd5, 32'h33, 32'h1234_5000, 32'h9, 32'h40, 2'd1, 1'b1, 1'b0);
    step();
    check("lui_result", 128'(data_result), 128'h1234_5000);
    in_valid = 1'b0;
    step();

    // Skid fill: A, B accepted, C held until space returns
    out_ready = 1'b0;
    offer(5'd10, 32'hA, 32'h100, 32'hAAAA, 32'h200, 2'd0, 1'b1, 1'b0);
    step();
    check("skid_ready_one", 128'(in_ready), 128'd1);
    offer(5'd11, 32'hB, 32'h100, 32'hBBBB, 32'h300, 2'd3, 1'b0, 1'b1);
    step();
    check("skid_ready_two", 128'(in_ready), 128'd0);
    offer(5'd12, 32'hC, 32'h8, 32'hCCCC, 32'h400, 2'd2, 1'b1, 1'b1);
    step();
    check("skid_c_held", 128'(in_ready), 128'd0);
    check("skid_head_a", 128'(data_result), 128'hAAAA);
    out_ready = 1'b1;
    step();
    check("skid_head_b", 128'(data_result), 128'h400);
    check("skid_ready_back", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check("skid_head_c", 128'(data_result), 128'h404);
    step();
    check("skid_drained", 128'(out_valid), 128'd0);

    // Flush in TWO with an offer pending
    out_ready = 1'b0;
    offer(5'd13, 32'hD, 32'h0, 32'hD0, 32'h0, 2'd0, 1'b0, 1'b1);
    step();
    offer(5'd14, 32'hE, 32'h0, 32'hE0, 32'h0, 2'd0, 1'b0, 1'b1);
    step();
    offer(5'd15, 32'hF, 32'h0, 32'hF0, 32'h0, 2'd0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 128'(out_valid), 128'd0);
    check("flush_in_ready", 128'(in_ready), 128'd1);
    check("flush_waddr", 128'(data_regWAddr), 128'd0);
    check("flush_mem_wr", 128'(data_mem_wr), 128'd0);
    out_ready = 1'b1;
    base = n_rel;
    repeat (3) step();
    check("flush_no_stale", 128'(n_rel - base), 128'd0);

    // Release in the flush cycle still completes
    offer(5'd16, 32'h16, 32'h0, 32'h1600, 32'h0, 2'd0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0; flush = 1'b1;
    base = n_rel;
    step();
    flush = 1'b0;
    check("flush_release_count", 128'(n_rel - base), 128'd1);
    check("flush_release_empty", 128'(out_valid), 128'd0);

    // Streaming: 8 entries, one release per cycle
    base = n_rel;
    for (int i = 0; i < 8; i++) begin
      offer(5'(i + 1), 32'(i), 32'(i * 16), 32'(i * 3), 32'(i * 4), 2'(i), 1'b0, 1'b0);
      step();
      check("stream_valid", 128'(out_valid), 128'd1);
      check("stream_ready", 128'(in_ready), 128'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_count", 128'(n_rel - base), 128'd8);

    // Reset while in TWO
    out_ready = 1'b0;
    offer(5'd20, 32'h20, 32'h0, 32'h2000, 32'h0, 2'd0, 1'b1, 1'b1);
    step();
    offer(5'd21, 32'h21, 32'h0, 32'h2100, 32'h0, 2'd0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    check("pre_reset_two", 128'(in_ready), 128'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_payload", 128'(out_pay), 128'd0);
    check("mid_rst_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    base = n_rel;
    repeat (3) step();
    check("mid_rst_no_stale", 128'(n_rel - base), 128'd0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      offer(5'($urandom), $urandom, $urandom, $urandom,
            (i % 7 == 0) ? 32'hFFFF_FFFC : $urandom, 2'($urandom), 1'($urandom), 1'($urandom));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    check("final_idle", 128'(out_valid), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter XLEN, 32, datapath width of operands, result and PC.
REQ-002 Parameter REG_AW, 5, register-file address width.
REQ-003 Parameter SKID_EN, 1, selects buffering: 1 = two-entry skid buffer, 0 = single register with combinational in_ready.
REQ-004 Port clk  in  1  single clock; every flop updates on its rising edge.
REQ-005 Port reset  in  1  reset; synchronous, active-high.
REQ-006 Ports in_valid/in_ready  in/out  1/1  upstream (EX) handshake.
REQ-007 Ports in_regWAddr  in  REG_AW, in_regRData2  in  XLEN, in_imm  in  XLEN, alu_result  in  XLEN, in_pc  in  XLEN  EX payload.
REQ-008 Ports ex_result_sel  in  2, in_mem_rd  in  1, in_mem_wr  in  1  result select and memory controls.
REQ-009 Port flush  in  1  pipeline flush.
REQ-010 Ports out_valid/out_ready  out/in  1/1  downstream (MEM) handshake.
REQ-011 Ports data_regWAddr  out  REG_AW, data_regRData2, data_result, data_pc  out  XLEN, data_mem_rd, data_mem_wr  out  1  MEM payload.

Function
REQ-012 Result select: 0 = alu_result; 1 = in_imm (LUI); 2 = in_pc+4 (JAL/JALR); 3 = in_pc+in_imm (AUIPC); sums are modulo 2^XLEN, carry discarded.
REQ-013 Result is computed combinationally in the accept cycle and stored; data_pc stores in_pc unmodified.
REQ-014 Accept occurs when in_valid && in_ready; release occurs when out_valid && out_ready; entries leave in acceptance order.
REQ-015 SKID_EN=1: states EMPTY, ONE, TWO; accept without release advances EMPTY->ONE->TWO; release without accept retreats; accept plus release in ONE stays ONE.
REQ-016 SKID_EN=1: in_ready is a registered signal, 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-017 SKID_EN=0: in_ready = !out_valid || out_ready; register loads on accept, clears valid on release without accept.
REQ-018 Latency: an entry accepted into an empty block appears on out_valid and the data outputs in the next cycle.
REQ-019 Payload outputs hold stable while out_valid=1 and out_ready=0.
REQ-020 When out_valid=0, data_regWAddr, data_mem_rd and data_mem_wr are 0, so a bubble carries no side effect.
REQ-021 Flush takes effect at the next clock edge and discards all stored entries; any input offered in the same cycle is not accepted.
REQ-022 After a flush: out_valid=0, state EMPTY, in_ready=1, all stored payload fields are 0.
REQ-023 Flush and reset asserted together: reset wins; the end result is the same.
REQ-024 A release in the flush cycle still completes downstream; the entry is then removed.

Reset
REQ-025 While reset is high at a clock edge, the state becomes EMPTY, out_valid=0, in_ready=1 (SKID_EN=1), and all payload outputs are 0.
REQ-026 Reset asserted mid-transfer drops every stored entry; no partial entry is released after reset.

Structure
REQ-027 Package ex_mem_pkg holds the ex_result_sel encodings (RES_ALU, RES_IMM, RES_PC4, RES_PCIMM) and the state encoding.
REQ-028 Sub-module pipe_skid_buf, parametrised by payload width, holds the handshake/state logic; ex_mem_pipe packs the payload into it and computes the result mux.

Verification
REQ-029 sel=3, pc=0x1000, imm=0x0002_0000, accept -> next cycle out_valid=1, data_result=0x0002_1000, data_pc=0x1000.
REQ-030 sel=2, pc=0xFFFF_FFFC -> data_result=0x0000_0000 (wrap-around); sel=1, imm=0x1234_5000 -> data_result=0x1234_5000.
REQ-031 SKID_EN=1, out_ready=0, three back-to-back offers A,B,C -> A and B accepted, in_ready=0 in the cycle after B, C held; out_ready=1 -> A, B, C released in order, one per cycle.
REQ-032 TWO state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, data_regWAddr=0, data_mem_wr=0; the offered entry is not released later.
REQ-033 Continuous in_valid=1, out_ready=1 for 8 entries -> 8 releases on 8 consecutive cycles, state stays ONE.
REQ-034 Reset pulse with the block in TWO -> next cycle out_valid=0, all outputs 0; no stale entry appears afterward.
